// File: rtl/intdiv_sub_unit.sv
// Registered SD2 conditional-negate and transfer-split stage for the integer divider.
// Each digit becomes a +1-weight sum bit and a -2-weight transfer bit, recombined carry-free.
module intdiv_sub_unit #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    input  logic           sub,
    input  logic [2*W-1:0] min,
    output logic           out_valid,
    output logic [W-1:0]   sum,
    output logic [W-1:0]   tr,
    output logic [2*W-1:0] res,
    output logic           tr_out
);

    logic [W-1:0]   sum_c;
    logic [W-1:0]   tr_c;
    logic [W-1:0]   tr_sh;
    logic [2*W-1:0] res_c;

    logic           valid_d, valid_q;
    logic [W-1:0]   sum_d, sum_q;
    logic [W-1:0]   tr_d, tr_q;
    logic [2*W-1:0] res_d, res_q;

    // Negation swaps p and n; both zero codes decompose to sum=0, tr=0.
    always_comb begin
        sum_c = '0;
        tr_c  = '0;
        for (int i = 0; i < W; i++) begin
            logic p_eff;
            logic n_eff;
            p_eff    = sub ? min[2*i]   : min[2*i+1];
            n_eff    = sub ? min[2*i+1] : min[2*i];
            sum_c[i] = p_eff ^ n_eff;
            tr_c[i]  = n_eff & ~p_eff;
        end
    end

    // Digit i takes its negative half from the transfer of digit i-1.
    always_comb begin
        tr_sh = tr_c << 1;
        res_c = '0;
        for (int i = 0; i < W; i++) begin
            res_c[2*i+1] = sum_c[i];
            res_c[2*i]   = tr_sh[i];
        end
    end

    always_comb begin
        valid_d = in_valid;
        sum_d   = sum_q;
        tr_d    = tr_q;
        res_d   = res_q;
        if (in_valid) begin
            sum_d = sum_c;
            tr_d  = tr_c;
            res_d = res_c;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            sum_q   <= '0;
            tr_q    <= '0;
            res_q   <= '0;
        end else begin
            valid_q <= valid_d;
            sum_q   <= sum_d;
            tr_q    <= tr_d;
            res_q   <= res_d;
        end
    end

    assign out_valid = valid_q;
    assign sum       = sum_q;
    assign tr        = tr_q;
    assign res       = res_q;
    assign tr_out    = tr_q[W-1];

endmodule

// File: tb/tb_intdiv_sub_unit.sv
// Self-checking bench for intdiv_sub_unit at W=1, W=4 and W=8 against an integer digit model.
module tb_intdiv_sub_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic       iv1 = 1'b0, sub1 = 1'b0;
    logic [1:0] min1 = '0;
    logic       ov1, tro1;
    logic [0:0] sum1, tr1;
    logic [1:0] res1;

    logic       iv4 = 1'b0, sub4 = 1'b0;
    logic [7:0] min4 = '0;
    logic       ov4, tro4;
    logic [3:0] sum4, tr4;
    logic [7:0] res4;

    logic        iv8 = 1'b0, sub8 = 1'b0;
    logic [15:0] min8 = '0;
    logic        ov8, tro8;
    logic [7:0]  sum8, tr8;
    logic [15:0] res8;

    intdiv_sub_unit #(.W(1)) u_w1 (.clk(clk), .rst_n(rst_n), .in_valid(iv1), .sub(sub1), .min(min1),
        .out_valid(ov1), .sum(sum1), .tr(tr1), .res(res1), .tr_out(tro1));
    intdiv_sub_unit #(.W(4)) u_w4 (.clk(clk), .rst_n(rst_n), .in_valid(iv4), .sub(sub4), .min(min4),
        .out_valid(ov4), .sum(sum4), .tr(tr4), .res(res4), .tr_out(tro4));
    intdiv_sub_unit #(.W(8)) u_w8 (.clk(clk), .rst_n(rst_n), .in_valid(iv8), .sub(sub8), .min(min8),
        .out_valid(ov8), .sum(sum8), .tr(tr8), .res(res8), .tr_out(tro8));

    // Reference model: digit values as signed integers.
    function automatic int digit_val(logic [15:0] x, int i);
        return int'(x[2*i+1]) - int'(x[2*i]);
    endfunction

    function automatic int sd_value(int w, logic [15:0] x);
        int v = 0;
        for (int i = 0; i < w; i++) v += digit_val(x, i) * (1 << i);
        return v;
    endfunction

    function automatic logic [7:0] exp_sum(int w, logic s, logic [15:0] x);
        logic [7:0] r = '0;
        for (int i = 0; i < w; i++) begin
            int d = s ? -digit_val(x, i) : digit_val(x, i);
            r[i] = (d != 0);
        end
        return r;
    endfunction

    function automatic logic [7:0] exp_tr(int w, logic s, logic [15:0] x);
        logic [7:0] r = '0;
        for (int i = 0; i < w; i++) begin
            int d = s ? -digit_val(x, i) : digit_val(x, i);
            r[i] = (d < 0);
        end
        return r;
    endfunction

    function automatic logic [15:0] exp_res(int w, logic [7:0] s, logic [7:0] t);
        logic [15:0] r = '0;
        for (int i = 0; i < w; i++) begin
            r[2*i+1] = s[i];
            r[2*i]   = (i > 0) ? t[i-1] : 1'b0;
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        iv1 = 1'b1; iv4 = 1'b1; iv8 = 1'b1;
        sub4 = 1'b1; sub8 = 1'b1;
        for (int c = 0; c < 2; c++) begin
            min1 = 2'($urandom); min4 = 8'($urandom); min8 = 16'($urandom);
            step();
        end
        n_tests++;
        if ({ov8, sum8, tr8, res8, tro8} !== '0) begin
            n_fail++;
            $display("FAIL reset_w8 got ov=%b sum=%h tr=%h res=%h tro=%b want all 0", ov8, sum8, tr8, res8, tro8);
        end
        n_tests++;
        if ({ov4, sum4, tr4, res4, tro4, ov1, sum1, tr1, res1, tro1} !== '0) begin
            n_fail++;
            $display("FAIL reset_w4_w1 got ov4=%b sum4=%h tr4=%h res4=%h ov1=%b res1=%b want all 0", ov4, sum4, tr4, res4, ov1, res1);
        end
        iv1 = 1'b0; iv4 = 1'b0; iv8 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_digit();
        logic [1:0] want;
        for (int s = 0; s < 2; s++) begin
            for (int m = 0; m < 4; m++) begin
                @(negedge clk);
                iv1 = 1'b1; sub1 = s[0]; min1 = m[1:0];
                // Required (sum,tr) written out directly.
                if (m == 2)      want = s ? 2'b11 : 2'b10;
                else if (m == 1) want = s ? 2'b10 : 2'b11;
                else             want = 2'b00;
                step();
                n_tests++;
                if ({sum1, tr1} !== want || ov1 !== 1'b1 || tro1 !== want[0] || res1 !== {want[1], 1'b0}) begin
                    n_fail++;
                    $display("FAIL single_digit sub=%0d min=%b got sum,tr=%b%b ov=%b res=%b tro=%b want %b", s, m[1:0], sum1, tr1, ov1, res1, tro1, want);
                end
            end
        end
        @(negedge clk);
        iv1 = 1'b0;
        step();
        n_tests++;
        if (ov1 !== 1'b0) begin
            n_fail++;
            $display("FAIL single_digit_valid_drop got ov=%b want 0", ov1);
        end
    endtask

    task automatic test_w4_vectors();
        logic [7:0] es, et;
        logic [15:0] er;
        int lhs, rhs;
        for (int s = 0; s < 2; s++) begin
            @(negedge clk);
            iv4 = 1'b1; sub4 = s[0]; min4 = 8'b10_01_00_10;
            es = exp_sum(4, sub4, {8'h0, min4});
            et = exp_tr(4, sub4, {8'h0, min4});
            er = exp_res(4, es, et);
            step();
            n_tests++;
            if (sum4 !== es[3:0] || tr4 !== et[3:0] || res4 !== er[7:0] || tro4 !== et[3] || ov4 !== 1'b1) begin
                n_fail++;
                $display("FAIL w4_vector sub=%0d got sum=%b tr=%b res=%b tro=%b want sum=%b tr=%b res=%b", s, sum4, tr4, res4, tro4, es[3:0], et[3:0], er[7:0]);
            end
            lhs = sd_value(4, {8'h0, res4}) - 16 * int'(tro4);
            rhs = s ? -5 : 5;
            n_tests++;
            if (lhs !== rhs) begin
                n_fail++;
                $display("FAIL w4_invariant sub=%0d got %0d want %0d", s, lhs, rhs);
            end
        end
        @(negedge clk);
        iv4 = 1'b0;
    endtask

    task automatic test_hold();
        logic [15:0] a;
        logic [7:0] es, et;
        logic [15:0] er;
        a = 16'($urandom);
        @(negedge clk);
        iv8 = 1'b1; sub8 = 1'b1; min8 = a;
        es = exp_sum(8, 1'b1, a); et = exp_tr(8, 1'b1, a); er = exp_res(8, es, et);
        step();
        n_tests++;
        if (ov8 !== 1'b1 || sum8 !== es || tr8 !== et || res8 !== er) begin
            n_fail++;
            $display("FAIL hold_capture got ov=%b sum=%h tr=%h res=%h want 1 %h %h %h", ov8, sum8, tr8, res8, es, et, er);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            iv8 = 1'b0; sub8 = c[0]; min8 = ~a ^ 16'($urandom);
            step();
            n_tests++;
            if (ov8 !== 1'b0 || sum8 !== es || tr8 !== et || res8 !== er || tro8 !== et[7]) begin
                n_fail++;
                $display("FAIL hold_idle cyc=%0d got ov=%b sum=%h tr=%h res=%h want 0 %h %h %h", c, ov8, sum8, tr8, res8, es, et, er);
            end
        end
    endtask

    task automatic test_reset_midstream();
        logic [15:0] b;
        logic [7:0] es, et;
        @(negedge clk);
        iv8 = 1'b1; sub8 = 1'b0; min8 = 16'hAAAA;
        rst_n = 1'b0;
        step();
        n_tests++;
        if ({ov8, sum8, tr8, res8} !== '0) begin
            n_fail++;
            $display("FAIL reset_midstream got ov=%b sum=%h res=%h want 0", ov8, sum8, res8);
        end
        @(negedge clk);
        rst_n = 1'b1;
        b = 16'($urandom) | 16'h8000;
        min8 = b; sub8 = 1'b1;
        es = exp_sum(8, 1'b1, b); et = exp_tr(8, 1'b1, b);
        step();
        n_tests++;
        if (ov8 !== 1'b1 || sum8 !== es || tr8 !== et) begin
            n_fail++;
            $display("FAIL reset_recover got ov=%b sum=%h tr=%h want 1 %h %h", ov8, sum8, tr8, es, et);
        end
        @(negedge clk);
        iv8 = 1'b0;
    endtask

    task automatic test_random();
        logic [7:0] es, et;
        logic [15:0] er;
        int lhs, rhs, bad_digit;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            iv8 = 1'b1; sub8 = 1'($urandom); min8 = 16'($urandom);
            es = exp_sum(8, sub8, min8); et = exp_tr(8, sub8, min8); er = exp_res(8, es, et);
            step();
            n_tests++;
            if (ov8 !== 1'b1 || sum8 !== es || tr8 !== et || res8 !== er || tro8 !== et[7]) begin
                n_fail++;
                $display("FAIL random_model cyc=%0d sub=%b min=%h got sum=%h tr=%h res=%h want %h %h %h", c, sub8, min8, sum8, tr8, res8, es, et, er);
            end
            lhs = sd_value(8, res8) - 256 * int'(tro8);
            rhs = sub8 ? -sd_value(8, min8) : sd_value(8, min8);
            n_tests++;
            if (lhs !== rhs) begin
                n_fail++;
                $display("FAIL random_invariant cyc=%0d got %0d want %0d", c, lhs, rhs);
            end
            bad_digit = -1;
            for (int i = 0; i < 8; i++) begin
                int v = sub8 ? -digit_val(min8, i) : digit_val(min8, i);
                if (int'(sum8[i]) - 2 * int'(tr8[i]) != v) bad_digit = i;
            end
            n_tests++;
            if (bad_digit !== -1) begin
                n_fail++;
                $display("FAIL random_digit_identity cyc=%0d digit=%0d got sum=%h tr=%h", c, bad_digit, sum8, tr8);
            end
        end
        @(negedge clk);
        iv8 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_digit();
        test_w4_vectors();
        test_hold();
        test_reset_midstream();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
